// File: rtl/fht_but_feeder_pkg.sv
// fht_pkg: shared constants and types for the FHT butterfly operand feeder.
//   N_LOG2_DEF : default log2 of the transform length
//   STAGE_W    : width of the stage counter for the default length
//   fsm_e      : sequencer state encoding
//   stage_w()  : stage-counter width for an arbitrary N_LOG2 (holds 0..N_LOG2)
package fht_pkg;

    localparam int N_LOG2_DEF = 10;
    localparam int STAGE_W    = $clog2(N_LOG2_DEF + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fsm_e;

    function automatic int stage_w(input int n_log2);
        return $clog2(n_log2 + 1);
    endfunction

endpackage

// File: rtl/fht_but_feeder_if.sv
// fht_but_feeder_if: start strobe plus every address/strobe/status signal the
// feeder drives toward the data RAM banks, twiddle ROM and butterfly.
//   master : the feeder (takes iSTART, drives all o* signals)
//   slave  : the surrounding datapath / controller
interface fht_but_feeder_if
    import fht_pkg::*;
#(
    parameter int N_LOG2 = N_LOG2_DEF
);
    localparam int SW = stage_w(N_LOG2);

    logic              iSTART;
    logic [N_LOG2-1:0] oRD_ADDR_0;
    logic [N_LOG2-1:0] oRD_ADDR_1;
    logic [N_LOG2-1:0] oRD_ADDR_2;
    logic              oRD_VALID;
    logic [N_LOG2-2:0] oTW_ADDR;
    logic              oRD_BANK;
    logic [N_LOG2-1:0] oWR_ADDR_0;
    logic [N_LOG2-1:0] oWR_ADDR_1;
    logic              oWR_EN;
    logic              oWR_BANK;
    logic [SW-1:0]     oSTAGE;
    logic              oBUSY;
    logic              oDONE;

    modport master (
        input  iSTART,
        output oRD_ADDR_0, oRD_ADDR_1, oRD_ADDR_2, oRD_VALID, oTW_ADDR, oRD_BANK,
        output oWR_ADDR_0, oWR_ADDR_1, oWR_EN, oWR_BANK, oSTAGE, oBUSY, oDONE
    );

    modport slave (
        output iSTART,
        input  oRD_ADDR_0, oRD_ADDR_1, oRD_ADDR_2, oRD_VALID, oTW_ADDR, oRD_BANK,
        input  oWR_ADDR_0, oWR_ADDR_1, oWR_EN, oWR_BANK, oSTAGE, oBUSY, oDONE
    );

endinterface

// File: rtl/fht_but_feeder_dly_line.sv
// fht_dly_line: W-bit wide, DEPTH-stage shift register with asynchronous
// active-low clear. q_o is d_i delayed by exactly DEPTH clocks.
//   clk, rst_n : clock, async active-low clear
//   d_i / q_o  : data in / delayed data out
module fht_dly_line #(
    parameter int W     = 1,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [DEPTH-1:0][W-1:0] pipe_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/fht_but_feeder.sv
// fht_but_feeder: walks all N_LOG2 stages of an in-place radix-2 FHT, issuing
// X0/X1/X2 read addresses and the twiddle index for one butterfly per cycle,
// and replays the matching Y0/Y1 write addresses RD_LAT+BUT_LAT cycles later.
//   iCLK, iRESET : clock, async active-low reset
//   bus          : fht_but_feeder_if master (iSTART in, read/write/status out)
module fht_but_feeder
    import fht_pkg::*;
#(
    parameter int N_LOG2  = N_LOG2_DEF,
    parameter int RD_LAT  = 1,
    parameter int BUT_LAT = 2
) (
    input  logic         iCLK,
    input  logic         iRESET,
    fht_but_feeder_if.master bus
);

    localparam int AW  = N_LOG2;
    localparam int SW  = stage_w(N_LOG2);
    localparam int D   = RD_LAT + BUT_LAT;
    localparam int DW  = (D > 1) ? $clog2(D) : 1;
    localparam int DLW = 2 * AW + 2;
    localparam logic [AW:0] N_FULL = {1'b1, {AW{1'b0}}};

    fsm_e           state_q;
    logic [SW-1:0]  s_q;
    logic [AW-1:0]  b_q, j_q;
    logic [DW-1:0]  dcnt_q;
    logic           bank_q, busy_q, done_q;

    logic [AW:0]    l_w;        // L = 2^s, one bit wider so L = N fits
    logic [AW-1:0]  h_a;        // H = L/2
    logic [AW-1:0]  x0, x1, x2;
    logic [AW-2:0]  tw;
    logic           last_j, last_b, rd_vld;
    logic [DLW-1:0] dly_in, dly_out;

    always_comb begin
        l_w    = {{AW{1'b0}}, 1'b1} << s_q;
        h_a    = AW'(l_w >> 1);
        x0     = b_q + j_q;
        x1     = x0 + h_a;
        // (H-j) mod H: H is a power of two, so the mod is a mask with H-1
        x2     = b_q + h_a + ((h_a - j_q) & (h_a - AW'(1)));
        tw     = (AW-1)'(j_q << (AW - int'(s_q)));
        last_j = (j_q == h_a - AW'(1));
        last_b = ({1'b0, b_q} == N_FULL - l_w);
        rd_vld = (state_q == ST_RUN);
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            b_q     <= '0;
            j_q     <= '0;
            dcnt_q  <= '0;
            bank_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (bus.iSTART) begin
                    state_q <= ST_RUN;
                    s_q     <= SW'(1);
                    b_q     <= '0;
                    j_q     <= '0;
                    bank_q  <= 1'b0;
                    busy_q  <= 1'b1;
                end
                ST_RUN: if (last_j) begin
                    j_q <= '0;
                    if (last_b) begin
                        state_q <= ST_DRAIN;
                        dcnt_q  <= '0;
                    end else begin
                        b_q <= b_q + l_w[AW-1:0];
                    end
                end else begin
                    j_q <= j_q + AW'(1);
                end
                // Hold reads off until the stage's last write has landed.
                ST_DRAIN: if (dcnt_q == DW'(D - 1)) begin
                    b_q <= '0;
                    if (s_q == SW'(N_LOG2)) begin
                        state_q <= ST_DONE;
                        s_q     <= '0;
                        bank_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= ST_RUN;
                        s_q     <= s_q + SW'(1);
                        bank_q  <= ~bank_q;
                    end
                end else begin
                    dcnt_q <= dcnt_q + DW'(1);
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Idle slots push zeros so the write-side outputs read 0 between writes.
    assign dly_in = rd_vld ? {1'b1, bank_q, x0, x1} : '0;

    fht_dly_line #(.W(DLW), .DEPTH(D)) u_dly (
        .clk   (iCLK),
        .rst_n (iRESET),
        .d_i   (dly_in),
        .q_o   (dly_out)
    );

    assign bus.oRD_ADDR_0 = rd_vld ? x0 : '0;
    assign bus.oRD_ADDR_1 = rd_vld ? x1 : '0;
    assign bus.oRD_ADDR_2 = rd_vld ? x2 : '0;
    assign bus.oTW_ADDR   = rd_vld ? tw : '0;
    assign bus.oRD_VALID  = rd_vld;
    assign bus.oRD_BANK   = bank_q;
    assign bus.oWR_EN     = dly_out[DLW-1];
    assign bus.oWR_BANK   = dly_out[DLW-1] & ~dly_out[DLW-2];
    assign bus.oWR_ADDR_0 = dly_out[2*AW-1:AW];
    assign bus.oWR_ADDR_1 = dly_out[AW-1:0];
    assign bus.oSTAGE     = s_q;
    assign bus.oBUSY      = busy_q;
    assign bus.oDONE      = done_q;

endmodule

// File: tb/tb_fht_but_feeder.sv
// Bench for fht_but_feeder at N_LOG2=3, RD_LAT=1, BUT_LAT=2. Expected per-cycle
// outputs come from a stage/group/butterfly walk of the transform (em[]).
module tb_fht_but_feeder;
    import fht_pkg::*;

    localparam int NL     = 3;
    localparam int NN     = 1 << NL;
    localparam int D      = 3;
    localparam int LAST_C = NL * (NN / 2 + D) + 1;   // oDONE cycle (22)
    localparam int MAXC   = 32;

    logic iCLK   = 1'b0;
    logic iRESET = 1'b0;

    fht_but_feeder_if #(.N_LOG2(NL)) bus ();

    fht_but_feeder #(.N_LOG2(NL), .RD_LAT(1), .BUT_LAT(2)) dut (
        .iCLK   (iCLK),
        .iRESET (iRESET),
        .bus    (bus)
    );

    always #5 iCLK = ~iCLK;

    typedef struct packed {
        logic       rdv;
        logic [2:0] a0, a1, a2;
        logic [1:0] tw;
        logic       rbank;
        logic       wen;
        logic [2:0] w0, w1;
        logic       wbank;
        logic [1:0] stg;
        logic       busy;
        logic       done;
    } obs_t;

    obs_t em [MAXC];
    obs_t ob [MAXC];
    int checks   = 0;
    int failures = 0;

    function automatic obs_t sample();
        obs_t o;
        o.rdv   = bus.oRD_VALID;
        o.a0    = bus.oRD_ADDR_0;
        o.a1    = bus.oRD_ADDR_1;
        o.a2    = bus.oRD_ADDR_2;
        o.tw    = bus.oTW_ADDR;
        o.rbank = bus.oRD_BANK;
        o.wen   = bus.oWR_EN;
        o.w0    = bus.oWR_ADDR_0;
        o.w1    = bus.oWR_ADDR_1;
        o.wbank = bus.oWR_BANK;
        o.stg   = bus.oSTAGE;
        o.busy  = bus.oBUSY;
        o.done  = bus.oDONE;
        return o;
    endfunction

    // Fields that carry no meaning in a cycle are taken from the expectation.
    function automatic obs_t mask_dc(obs_t o, obs_t e);
        obs_t m = o;
        if (!e.rdv) begin
            m.a0 = e.a0; m.a1 = e.a1; m.a2 = e.a2; m.tw = e.tw;
        end
        if (!e.busy) m.rbank = e.rbank;
        if (!e.wen) begin
            m.w0 = e.w0; m.w1 = e.w1; m.wbank = e.wbank;
        end
        return m;
    endfunction

    function automatic void build_model();
        int c;
        for (int i = 0; i < MAXC; i++) em[i] = '0;
        c = 1;
        for (int s = 1; s <= NL; s++) begin
            int L = 1 << s;
            int H = L / 2;
            for (int b = 0; b < NN; b += L) begin
                for (int j = 0; j < H; j++) begin
                    em[c].rdv     = 1'b1;
                    em[c].a0      = 3'(b + j);
                    em[c].a1      = 3'(b + H + j);
                    em[c].a2      = 3'(b + H + ((H - j) % H));
                    em[c].tw      = 2'(j << (NL - s));
                    em[c].rbank   = 1'((s - 1) % 2);
                    em[c].busy    = 1'b1;
                    em[c].stg     = 2'(s);
                    em[c+D].wen   = 1'b1;
                    em[c+D].w0    = 3'(b + j);
                    em[c+D].w1    = 3'(b + H + j);
                    em[c+D].wbank = 1'(s % 2);
                    c++;
                end
            end
            for (int k = 0; k < D; k++) begin
                em[c].busy  = 1'b1;
                em[c].stg   = 2'(s);
                em[c].rbank = 1'((s - 1) % 2);
                c++;
            end
        end
        em[c].done = 1'b1;
    endfunction

    // Pulses iSTART in the current cycle, then records nc cycles of outputs.
    task automatic play_run(input int spur_pct, input bit start_on_done, input int nc);
        bus.iSTART = 1'b1;
        for (int c = 1; c <= nc; c++) begin
            @(posedge iCLK); #1;
            bus.iSTART = 1'b0;
            if (c < LAST_C && spur_pct > 0 &&
                (c == 6 || c == 9 || c == 13 || c == 21 || $urandom_range(0, 99) < spur_pct))
                bus.iSTART = 1'b1;
            if (c == LAST_C && start_on_done) bus.iSTART = 1'b1;
            @(negedge iCLK);
            ob[c] = sample();
        end
        bus.iSTART = 1'b0;
    endtask

    task automatic test_reset();
        obs_t o;
        bus.iSTART = 1'b0;
        iRESET     = 1'b0;
        #12;
        o = sample();
        checks++;
        if (o !== '0) begin
            failures++;
            $display("FAIL reset_state: got %h expected %h", o, obs_t'(0));
        end
        @(posedge iCLK); #1;
        iRESET = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge iCLK);
            o = sample();
            checks++;
            if (o !== '0) begin
                failures++;
                $display("FAIL idle_after_reset k=%0d: got %h expected %h", k, o, obs_t'(0));
            end
        end
    endtask

    task automatic test_basic_run();
        int busy_n, done_n;
        int exp3 [4][4] = '{'{0, 4, 4, 0}, '{1, 5, 7, 1}, '{2, 6, 6, 2}, '{3, 7, 5, 3}};
        play_run(0, 1'b0, 24);
        for (int c = 1; c <= 24; c++) begin
            checks++;
            if (mask_dc(ob[c], em[c]) !== em[c]) begin
                failures++;
                $display("FAIL basic_run cycle %0d: got %h expected %h", c, ob[c], em[c]);
            end
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({ob[1+k].rdv, ob[1+k].a0, ob[1+k].a1, ob[1+k].a2, ob[1+k].tw, ob[1+k].rbank} !==
                {1'b1, 3'(2*k), 3'(2*k+1), 3'(2*k+1), 2'd0, 1'b0}) begin
                failures++;
                $display("FAIL stage1_read k=%0d: got %h expected a0=%0d a1/a2=%0d", k, ob[1+k], 2*k, 2*k+1);
            end
            checks++;
            if ({ob[4+k].wen, ob[4+k].w0, ob[4+k].wbank} !== {1'b1, 3'(2*k), 1'b1}) begin
                failures++;
                $display("FAIL stage1_write k=%0d: got %h expected w0=%0d bank 1", k, ob[4+k], 2*k);
            end
            checks++;
            if ({ob[15+k].a0, ob[15+k].a1, ob[15+k].a2, ob[15+k].tw} !==
                {3'(exp3[k][0]), 3'(exp3[k][1]), 3'(exp3[k][2]), 2'(exp3[k][3])}) begin
                failures++;
                $display("FAIL stage3_read k=%0d: got %h expected %0d,%0d,%0d tw %0d",
                         k, ob[15+k], exp3[k][0], exp3[k][1], exp3[k][2], exp3[k][3]);
            end
        end
        busy_n = 0;
        done_n = 0;
        for (int c = 1; c <= 24; c++) begin
            busy_n += int'(ob[c].busy);
            done_n += int'(ob[c].done);
        end
        checks++;
        if (busy_n != NL * (NN / 2 + D)) begin
            failures++;
            $display("FAIL busy_length: got %0d expected %0d", busy_n, NL * (NN / 2 + D));
        end
        checks++;
        if (done_n != 1 || !ob[LAST_C].done || !ob[LAST_C-1].wen) begin
            failures++;
            $display("FAIL done_pulse: got count %0d at %0d expected single pulse at %0d", done_n,
                     ob[LAST_C].done, LAST_C);
        end
    endtask

    task automatic test_start_while_busy();
        play_run(25, 1'b0, 24);
        for (int c = 1; c <= 24; c++) begin
            checks++;
            if (mask_dc(ob[c], em[c]) !== em[c]) begin
                failures++;
                $display("FAIL start_while_busy cycle %0d: got %h expected %h", c, ob[c], em[c]);
            end
        end
    endtask

    task automatic test_back_to_back();
        play_run(0, 1'b1, LAST_C + 1);
        for (int c = 1; c <= LAST_C + 1; c++) begin
            checks++;
            if (mask_dc(ob[c], em[c]) !== em[c]) begin
                failures++;
                $display("FAIL start_on_done cycle %0d: got %h expected %h", c, ob[c], em[c]);
            end
        end
        play_run(0, 1'b0, 24);
        for (int c = 1; c <= 24; c++) begin
            checks++;
            if (mask_dc(ob[c], em[c]) !== em[c]) begin
                failures++;
                $display("FAIL back_to_back cycle %0d: got %h expected %h", c, ob[c], em[c]);
            end
        end
    endtask

    task automatic test_midrun_reset();
        obs_t o;
        int rc = int'($urandom_range(8, 11));
        bus.iSTART = 1'b1;
        for (int c = 1; c <= rc; c++) begin
            @(posedge iCLK); #1;
            bus.iSTART = 1'b0;
            @(negedge iCLK);
            o = sample();
            checks++;
            if (mask_dc(o, em[c]) !== em[c]) begin
                failures++;
                $display("FAIL pre_reset cycle %0d: got %h expected %h", c, o, em[c]);
            end
        end
        #2;
        iRESET = 1'b0;
        #1;
        o = sample();
        checks++;
        if (o !== '0) begin
            failures++;
            $display("FAIL async_reset at cycle %0d: got %h expected %h", rc, o, obs_t'(0));
        end
        @(posedge iCLK); #1;
        @(posedge iCLK); #1;
        iRESET = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge iCLK);
            o = sample();
            checks++;
            if (o !== '0) begin
                failures++;
                $display("FAIL post_reset_idle k=%0d: got %h expected %h", k, o, obs_t'(0));
            end
        end
        play_run(0, 1'b0, 24);
        for (int c = 1; c <= 24; c++) begin
            checks++;
            if (mask_dc(ob[c], em[c]) !== em[c]) begin
                failures++;
                $display("FAIL rerun_after_reset cycle %0d: got %h expected %h", c, ob[c], em[c]);
            end
        end
    endtask

    initial begin
        bus.iSTART = 1'b0;
        build_model();
        test_reset();
        test_basic_run();
        test_start_while_busy();
        test_back_to_back();
        test_midrun_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
